// File: rtl/bus_capture_reader.sv
// bus_capture_reader
//
// Reads one value from a shared tri-state bus. The block enables exactly one
// of NSRC drivers (active-low oe_bar), waits SETTLE cycles for the bus to
// settle, captures it and reports completion with a one-cycle valid pulse.
//
// Optional feature (macro BUS_STABLE_CHECK_EN): after the first sample the
// bus is re-sampled in a CHECK state until two consecutive samples agree;
// MAX_RETRY consecutive mismatches end the read with err=1. Without the macro
// a single sample is taken and err only flags an out-of-range src_sel.
//
// Ports
//   clk      in   clock, all state changes on the rising edge
//   reset    in   asynchronous active-high reset
//   req      in   read request, sampled only in IDLE
//   src_sel  in   SEL_W  driver index, sampled with req
//   bus      in   WIDTH  shared bus value
//   oe_bar   out  NSRC   active-low driver enables, at most one low
//   data     out  WIDTH  last captured bus value
//   valid    out  one-cycle completion pulse
//   err      out  completion status, meaningful while valid=1
//   busy     out  high whenever the block is not IDLE
//
// src_sel is $clog2(NSRC+1) bits wide: the smallest width that can still
// carry the out-of-range value NSRC, so the error path is reachable even when
// NSRC is a power of two. For non-power-of-two NSRC this equals $clog2(NSRC).

module bus_capture_reader #(
  parameter int WIDTH     = 8,
  parameter int NSRC      = 4,
  parameter int SETTLE    = 2,
  parameter int MAX_RETRY = 3,
  localparam int SEL_W    = $clog2(NSRC + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [SEL_W-1:0] src_sel,
  input  logic [WIDTH-1:0] bus,
  output logic [NSRC-1:0]  oe_bar,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             err,
  output logic             busy
);

  localparam int CNT_W = $clog2(SETTLE + 1);

  if (SETTLE < 1 || MAX_RETRY < 1) begin : g_bad_param
    $error("bus_capture_reader: SETTLE and MAX_RETRY must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
`ifdef BUS_STABLE_CHECK_EN
    ST_CHECK  = 2'd2,
`endif
    ST_DONE   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel, sel_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic             err_nxt;
  logic [NSRC-1:0]  oe_bar_nxt;
  logic             drive_nxt;

`ifdef BUS_STABLE_CHECK_EN
  localparam int RTY_W = $clog2(MAX_RETRY + 1);
  logic [RTY_W-1:0] retry, retry_nxt;
`endif

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    cnt_nxt   = cnt;
    data_nxt  = data;
    err_nxt   = err;
`ifdef BUS_STABLE_CHECK_EN
    retry_nxt = retry;
`endif
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (src_sel < SEL_W'(NSRC)) begin
            sel_nxt   = src_sel;
            cnt_nxt   = '0;
`ifdef BUS_STABLE_CHECK_EN
            retry_nxt = '0;
`endif
            err_nxt   = 1'b0;
            state_nxt = ST_SETTLE;
          end else begin
            // No driver is enabled and data is left untouched.
            err_nxt   = 1'b1;
            state_nxt = ST_DONE;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt == CNT_W'(SETTLE - 1)) begin
          data_nxt  = bus;
`ifdef BUS_STABLE_CHECK_EN
          state_nxt = ST_CHECK;
`else
          state_nxt = ST_DONE;
`endif
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`ifdef BUS_STABLE_CHECK_EN
      ST_CHECK: begin
        if (bus == data) begin
          err_nxt   = 1'b0;
          state_nxt = ST_DONE;
        end else begin
          // Keep the newest sample so the next compare is against it.
          data_nxt  = bus;
          retry_nxt = retry + 1'b1;
          if (retry == RTY_W'(MAX_RETRY - 1)) begin
            err_nxt   = 1'b1;
            state_nxt = ST_DONE;
          end
        end
      end
`endif
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Enables are registered so the tri-state controls never see decode glitches.
  always_comb begin
    drive_nxt = (state_nxt == ST_SETTLE);
`ifdef BUS_STABLE_CHECK_EN
    drive_nxt = drive_nxt || (state_nxt == ST_CHECK);
`endif
    oe_bar_nxt = '1;
    for (int i = 0; i < NSRC; i++) begin
      if (drive_nxt && (sel_nxt == SEL_W'(i))) begin
        oe_bar_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      sel    <= '0;
      cnt    <= '0;
      data   <= '0;
      err    <= 1'b0;
      oe_bar <= '1;
      valid  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      sel    <= sel_nxt;
      cnt    <= cnt_nxt;
      data   <= data_nxt;
      err    <= err_nxt;
      oe_bar <= oe_bar_nxt;
      valid  <= (state_nxt == ST_DONE);
      busy   <= (state_nxt != ST_IDLE);
    end
  end

`ifdef BUS_STABLE_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retry <= '0;
    end else begin
      retry <= retry_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_bus_capture_reader.sv
// Directed testbench for bus_capture_reader with default parameters.
// Works for both builds: expectations that depend on BUS_STABLE_CHECK_EN
// are selected with the same macro.

module tb_bus_capture_reader;

  localparam int WIDTH     = 8;
  localparam int NSRC      = 4;
  localparam int SETTLE    = 2;
  localparam int MAX_RETRY = 3;
  localparam int SEL_W     = $clog2(NSRC + 1);

`ifdef BUS_STABLE_CHECK_EN
  localparam int        LAT      = SETTLE + 1;
  localparam int        TOG_LAT  = SETTLE + MAX_RETRY;
  localparam logic [7:0] TOG_DATA = 8'hFF;
  localparam logic      TOG_ERR  = 1'b1;
`else
  localparam int        LAT      = SETTLE;
  localparam int        TOG_LAT  = SETTLE;
  localparam logic [7:0] TOG_DATA = 8'h00;
  localparam logic      TOG_ERR  = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             req;
  logic [SEL_W-1:0] src_sel;
  logic [WIDTH-1:0] bus;
  logic [NSRC-1:0]  oe_bar;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             err;
  logic             busy;

  int n_chk = 0;
  int n_bad = 0;

  bus_capture_reader #(
    .WIDTH    (WIDTH),
    .NSRC     (NSRC),
    .SETTLE   (SETTLE),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .src_sel(src_sel),
    .bus    (bus),
    .oe_bar (oe_bar),
    .data   (data),
    .valid  (valid),
    .err    (err),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // Issues a one-cycle request; returns at the falling edge after the accept edge.
  task automatic start_read(input int sel, input logic [7:0] b);
    req     = 1'b1;
    src_sel = SEL_W'(sel);
    bus     = b;
    tick();
    req     = 1'b0;
  endtask

  // Follows an accepted read with a stable bus through DONE and back to IDLE.
  task automatic finish_read(input string tag, input logic [3:0] exp_oe, input logic [7:0] exp_data);
    check_eq({tag, "_oe0"}, oe_bar, exp_oe);
    check_eq({tag, "_busy"}, busy, 1'b1);
    for (int k = 1; k < LAT; k++) begin
      tick();
      check_eq({tag, "_oe"}, oe_bar, exp_oe);
      check_eq({tag, "_vld_early"}, valid, 1'b0);
    end
    tick();
    check_eq({tag, "_valid"}, valid, 1'b1);
    check_eq({tag, "_data"}, data, exp_data);
    check_eq({tag, "_err"}, err, 1'b0);
    check_eq({tag, "_oe_done"}, oe_bar, 4'b1111);
    tick();
    check_eq({tag, "_vld_off"}, valid, 1'b0);
    check_eq({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    int seen_valid;
    int prev;
    int n_valid;
    int multi;

    reset   = 1'b1;
    req     = 1'b0;
    src_sel = '0;
    bus     = '0;

    // Reset state, before any clock edge
    #2;
    check_eq("rst_oe", oe_bar, 4'b1111);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_valid", valid, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_data", data, 8'h00);
    tick();
    reset = 1'b0;
    tick();

    // Basic read from driver 1
    start_read(1, 8'hA5);
    finish_read("rd_a5", 4'b1101, 8'hA5);

    // Read from driver 3
    start_read(3, 8'h3C);
    finish_read("rd_3c", 4'b0111, 8'h3C);

    // Out-of-range source: immediate error, no driver enabled, data held
    bus = 8'h77;
    start_read(4, 8'h77);
    check_eq("oor_valid", valid, 1'b1);
    check_eq("oor_err", err, 1'b1);
    check_eq("oor_oe", oe_bar, 4'b1111);
    check_eq("oor_data", data, 8'h3C);
    tick();
    check_eq("oor_vld_off", valid, 1'b0);
    check_eq("oor_idle", busy, 1'b0);

    // Reset pulsed between edges in the middle of SETTLE
    start_read(0, 8'h5A);
    check_eq("abort_oe_pre", oe_bar, 4'b1110);
    #2;
    reset = 1'b1;
    #1;
    check_eq("abort_oe", oe_bar, 4'b1111);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_valid", valid, 1'b0);
    check_eq("abort_data", data, 8'h00);
    #1;
    reset = 1'b0;
    seen_valid = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (valid === 1'b1) seen_valid++;
    end
    check_eq("abort_no_valid", seen_valid, 0);
    start_read(2, 8'h96);
    finish_read("rd_after_rst", 4'b1011, 8'h96);

    // Bus toggling every cycle
    req     = 1'b1;
    src_sel = SEL_W'(2);
    bus     = 8'h00;
    tick();
    req = 1'b0;
    for (int k = 1; k <= TOG_LAT; k++) begin
      check_eq("tog_oe", oe_bar, 4'b1011);
      check_eq("tog_vld_early", valid, 1'b0);
      bus = ~bus;
      tick();
    end
    check_eq("tog_valid", valid, 1'b1);
    check_eq("tog_err", err, TOG_ERR);
    check_eq("tog_data", data, TOG_DATA);
    check_eq("tog_oe_done", oe_bar, 4'b1111);
    tick();
    check_eq("tog_idle", busy, 1'b0);

    // req held high: back-to-back reads, one IDLE cycle between DONE and accept
    bus     = 8'h11;
    src_sel = SEL_W'(1);
    req     = 1'b1;
    prev    = -1;
    n_valid = 0;
    multi   = 0;
    for (int i = 0; i < 3 * (LAT + 2) + 2; i++) begin
      tick();
      if ($countones(~oe_bar) > 1) multi++;
      if (valid === 1'b1) begin
        if (prev >= 0) check_eq("b2b_gap", i - prev, LAT + 2);
        prev = i;
        n_valid++;
        check_eq("b2b_data", data, 8'h11);
      end
    end
    req = 1'b0;
    check_eq("b2b_onehot", multi, 0);
    check_eq("b2b_count", (n_valid >= 3), 1'b1);
    for (int k = 0; k < LAT + 3; k++) tick();
    check_eq("b2b_idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
